// File: rtl/im_bank_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | im_bank_arbiter_pkg: shared constants and helpers for the item-memory bank |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package im_bank_arbiter_pkg;

  localparam int HV_DIMENSION    = 2000;
  localparam int INPUT_CHANNELS  = 214;
  localparam int IM_ADDR_WIDTH   = $clog2(INPUT_CHANNELS);
  localparam int NUM_MODALITIES  = 3;
  localparam int IM_READ_LATENCY = 2;

  // Requester index width; a single requester still needs one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/im_bank_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | im_bank_arbiter_if: requester/response/SRAM signals of the shared bank     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface im_bank_arbiter_if #(
  parameter int HV_DIMENSION = 2000,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_REQ      = 3
);

  logic [NUM_REQ-1:0]              ReqValid_SI;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   ReqAddr_DI;
  logic [NUM_REQ-1:0]              ReqReady_SO;
  logic [NUM_REQ-1:0]              RspValid_SO;
  logic [NUM_REQ-1:0]              RspReady_SI;
  logic [NUM_REQ*HV_DIMENSION-1:0] RspData_DO;
  logic                            SramEn_SO;
  logic [ADDR_WIDTH-1:0]           SramAddr_DO;
  logic [HV_DIMENSION-1:0]         SramRdata_DI;

  modport slave (
    input  ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
    output ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
  );

  modport master (
    output ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
    input  ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
  );

endinterface

`default_nettype wire

// File: rtl/im_bank_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | im_bank_arbiter_rr_arbiter: round-robin select with a registered pointer   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module im_bank_arbiter_rr_arbiter
  import im_bank_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = tag_width(N)
) (
  input  wire logic             Clk_CI,
  input  wire logic             Reset_RI,
  input  wire logic [N-1:0]     req_i,
  input  wire logic             advance_i,
  output logic      [N-1:0]     grant_o,
  output logic      [IDX_W-1:0] grant_idx_o,
  output logic                  grant_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand_w;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand_w      = '0;
    for (int k = 0; k < N; k++) begin
      cand_w = IDX_W'((int'(ptr_q) + k) % N);
      if (!grant_vld_o && req_i[cand_w]) begin
        grant_vld_o     = 1'b1;
        grant_idx_o     = cand_w;
        grant_o[cand_w] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && grant_vld_o) begin
      ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/im_bank_arbiter.sv
// +----------------------------------------------------------------------------+
// | im_bank_arbiter: shares one fixed-latency SRAM read port among requesters  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module im_bank_arbiter
  import im_bank_arbiter_pkg::*;
#(
  parameter int HV_DIMENSION = im_bank_arbiter_pkg::HV_DIMENSION,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_REQ      = NUM_MODALITIES,
  parameter int READ_LATENCY = IM_READ_LATENCY
) (
  input  wire logic         Clk_CI,
  input  wire logic         Reset_RI,
  im_bank_arbiter_if.slave  bus
);

  localparam int IDX_W = tag_width(NUM_REQ);

  logic [NUM_REQ-1:0]                   eligible_w, grant_w, pop_w, cap_hit_w;
  logic [IDX_W-1:0]                     gnt_idx_w;
  logic                                 gnt_vld_w;
  logic [ADDR_WIDTH-1:0]                gnt_addr_w;
  logic [ADDR_WIDTH-1:0]                sram_addr_q;
  logic [NUM_REQ-1:0]                   rsp_valid_q, inflight_q;
  logic [NUM_REQ-1:0][HV_DIMENSION-1:0] slot_data_q;
  logic [READ_LATENCY-1:0]              tag_vld_q;
  logic [READ_LATENCY-1:0][IDX_W-1:0]   tag_idx_q;

  // Grants are masked while reset is held so ReqReady_SO reads zero during reset.
  assign pop_w      = rsp_valid_q & bus.RspReady_SI;
  assign eligible_w = bus.ReqValid_SI & ~inflight_q & (~rsp_valid_q | bus.RspReady_SI)
                    & {NUM_REQ{~Reset_RI}};

  im_bank_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .Clk_CI      (Clk_CI),
    .Reset_RI    (Reset_RI),
    .req_i       (eligible_w),
    .advance_i   (1'b1),
    .grant_o     (grant_w),
    .grant_idx_o (gnt_idx_w),
    .grant_vld_o (gnt_vld_w)
  );

  always_comb begin
    gnt_addr_w = '0;
    cap_hit_w  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_w[i]) gnt_addr_w = bus.ReqAddr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
      cap_hit_w[i] = tag_vld_q[READ_LATENCY-1] && (tag_idx_q[READ_LATENCY-1] == IDX_W'(i));
    end
  end

  assign bus.ReqReady_SO = grant_w;
  assign bus.SramEn_SO   = gnt_vld_w;
  assign bus.SramAddr_DO = gnt_vld_w ? gnt_addr_w : sram_addr_q;
  assign bus.RspValid_SO = rsp_valid_q;
  assign bus.RspData_DO  = slot_data_q;

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      sram_addr_q <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
    end else begin
      if (gnt_vld_w) sram_addr_q <= gnt_addr_w;
      tag_vld_q[0] <= gnt_vld_w;
      tag_idx_q[0] <= gnt_idx_w;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  // A capture never meets a pop or a grant on the same slot: inflight excludes both.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      rsp_valid_q <= '0;
      inflight_q  <= '0;
      slot_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_hit_w[i]) begin
          rsp_valid_q[i] <= 1'b1;
          slot_data_q[i] <= bus.SramRdata_DI;
        end else if (pop_w[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
        if (grant_w[i])        inflight_q[i] <= 1'b1;
        else if (cap_hit_w[i]) inflight_q[i] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
